// File: rtl/doc_pkg.sv
// Shared definitions for the document messenger and loader: frame markers, page geometry,
// loader state encoding and the ASCII-to-internal character conversion.
package doc_pkg;

    localparam logic [7:0] SIGACK     = 8'hCC;
    localparam logic [7:0] SIGEOF     = 8'hDD;
    localparam logic [7:0] ASCII_BIAS = 8'h20;
    localparam int         ROWS       = 15;
    localparam int         COLS       = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_RECV,
        S_FILL,
        S_DONE,
        S_ERR
    } doc_state_e;

    // Printable ASCII maps onto the biased internal code; everything else becomes a space.
    function automatic logic [7:0] to_internal(input logic [7:0] b);
        if (b >= ASCII_BIAS && b <= 8'h7E) begin
            return b - ASCII_BIAS;
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/uart_rx_mid.sv
// Mid-bit sampling UART receiver (8N1, LSB first) with a 2-FF input synchronizer.
// With UART_DOC_LOADER_TIMEOUT_EN defined it also exports rx_busy (mid-byte indicator).
module uart_rx_mid #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
`ifdef UART_DOC_LOADER_TIMEOUT_EN
    ,
    output logic       rx_busy
`endif
);

    localparam int HALF = BAUD_DIV / 2;
    localparam int CW   = $clog2(BAUD_DIV);

    logic          sync1_q, sync2_q, prev_q;
    logic          active_q;
    logic [3:0]    phase_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    shift_q;
    logic          valid_q, ferr_q;

    // phase 0 = start-bit recheck, 1..8 = data bits, 9 = stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            active_q <= 1'b0;
            phase_q  <= 4'd0;
            cnt_q    <= '0;
            shift_q  <= 8'h00;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (!active_q) begin
                if (prev_q && !sync2_q) begin
                    active_q <= 1'b1;
                    phase_q  <= 4'd0;
                    cnt_q    <= CW'(HALF - 1);
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                cnt_q   <= CW'(BAUD_DIV - 1);
                phase_q <= phase_q + 4'd1;
                if (phase_q == 4'd0) begin
                    if (sync2_q) begin
                        active_q <= 1'b0;
                    end
                end else if (phase_q <= 4'd8) begin
                    shift_q <= {sync2_q, shift_q[7:1]};
                end else begin
                    active_q <= 1'b0;
                    valid_q  <= sync2_q;
                    ferr_q   <= !sync2_q;
                end
            end
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = shift_q;
    assign rx_ferr  = ferr_q;
`ifdef UART_DOC_LOADER_TIMEOUT_EN
    assign rx_busy  = active_q;
`endif

endmodule

// File: rtl/uart_doc_loader.sv
// Receives a 0xCC ... 0xDD framed document over UART and writes it into document memory.
// Optional idle-line timeout is compiled in with UART_DOC_LOADER_TIMEOUT_EN.
module uart_doc_loader
    import doc_pkg::*;
#(
    parameter int BAUD_DIV = 434
`ifdef UART_DOC_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RsRx,
    input  logic       load,
    output logic       write_en,
    output logic [9:0] write_addr,
    output logic [7:0] write_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    doc_state_e state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       full_q, full_d;
    logic       error_q, error_d;
    logic       wen_q, wen_d;
    logic [9:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       do_write;
    logic [7:0] wr_byte;
    logic       at_last;
    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

`ifdef UART_DOC_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_busy;
    logic          waiting;
    logic          timeout_hit;
`endif

    uart_rx_mid #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (RsRx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
`ifdef UART_DOC_LOADER_TIMEOUT_EN
        ,
        .rx_busy  (rx_busy)
`endif
    );

    assign at_last = (row_q == 4'(ROWS - 1)) && (col_q == 5'(COLS - 1));

`ifdef UART_DOC_LOADER_TIMEOUT_EN
    // Counter holds while a byte is in flight so a slow byte never looks like a dead line.
    assign waiting     = (state_q == S_WAIT_ACK) || (state_q == S_RECV);
    assign timeout_hit = waiting && !rx_valid && !rx_ferr && (tmo_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == S_IDLE && load) || rx_valid || rx_ferr) begin
            tmo_d = '0;
        end else if (waiting && !rx_busy && tmo_q != TW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        full_d   = full_q;
        error_d  = error_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        do_write = 1'b0;
        wr_byte  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    row_d   = 4'd0;
                    col_d   = 5'd0;
                    full_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (rx_valid && rx_data == SIGACK) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_ferr) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    if (rx_data == SIGEOF) begin
                        state_d = full_q ? S_DONE : S_FILL;
                    end else if (rx_data == SIGACK) begin
                        row_d  = 4'd0;
                        col_d  = 5'd0;
                        full_d = 1'b0;
                    end else if (full_q) begin
                        state_d = S_ERR;
                    end else begin
                        do_write = 1'b1;
                        wr_byte  = to_internal(rx_data);
                    end
                end
            end
            S_FILL: begin
                do_write = 1'b1;
                if (at_last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cursor saturates on the last cell; the full flag marks that it was written.
        if (do_write) begin
            wen_d   = 1'b1;
            waddr_d = {1'b0, row_q, col_q};
            wdata_d = wr_byte;
            if (at_last) begin
                full_d = 1'b1;
            end else if (col_q == 5'(COLS - 1)) begin
                col_d = 5'd0;
                row_d = row_q + 4'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end

`ifdef UART_DOC_LOADER_TIMEOUT_EN
        if (timeout_hit) begin
            state_d = S_ERR;
        end
`endif
        if (state_d == S_ERR) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= 4'd0;
            col_q   <= 5'd0;
            full_q  <= 1'b0;
            error_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= 10'd0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            full_q  <= full_d;
            error_q <= error_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign write_en   = wen_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;

endmodule
